// File: rtl/seg_display_sequencer.sv
// seg_display_sequencer
// Loads a 16-bit value over a valid/ready handshake. It decodes one nibble per
// cycle through a single shared hex-to-7-segment decoder into a shadow
// register, then commits all four digits to the display in a single cycle.
// Segment codes are active-low, and bit 7 (the decimal point) is always off.
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready.
// in_ready is a registered flag that is high only while the FSM is in IDLE.
// It stays low for the first cycle after reset. The source must hold
// in_valid and in_value until that edge; after the edge in_value is
// don't-care.
module seg_display_sequencer #(
    parameter bit         BLANK_LZ   = 1'b1,
    parameter logic [7:0] BLANK_CODE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic [3:0]  digit_en,
    output logic [31:0] out_7seg,
    output logic        busy,
    output logic        update_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [1:0]  idx_q,    idx_d;
    logic [15:0] value_q,  value_d;
    logic [3:0]  en_q,     en_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] out_q,    out_d;
    logic        ready_q,  ready_d;
    logic        done_q,   done_d;

    logic [3:0]  nibble;
    logic        upper_zero;
    logic [6:0]  seg_on;
    logic [7:0]  digit_code;

    // Active-high segment pattern {g,f,e,d,c,b,a} for a hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Select the current nibble and decide whether it counts as a leading
    // zero. The test looks at the captured value (digits idx..3), never at
    // the shadow register. Digit 0 is never treated as a leading zero.
    always_comb begin
        nibble     = 4'h0;
        upper_zero = 1'b0;
        case (idx_q)
            2'd0: begin
                nibble     = value_q[3:0];
                upper_zero = 1'b0;
            end
            2'd1: begin
                nibble     = value_q[7:4];
                upper_zero = (value_q[15:4] == 12'h000);
            end
            2'd2: begin
                nibble     = value_q[11:8];
                upper_zero = (value_q[15:8] == 8'h00);
            end
            default: begin
                nibble     = value_q[15:12];
                upper_zero = (value_q[15:12] == 4'h0);
            end
        endcase
    end

    // Shared decoder plus the digit priority: disable, then leading-zero
    // blank, then the decoded glyph.
    always_comb begin
        seg_on     = hex_to_seg(nibble);
        digit_code = {1'b1, ~seg_on};
        if (!en_q[idx_q]) begin
            digit_code = BLANK_CODE;
        end else if (BLANK_LZ && upper_zero) begin
            digit_code = BLANK_CODE;
        end
    end

    // Next-state logic for the IDLE -> CONV x4 -> COMMIT sequence.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        value_d  = value_q;
        en_d     = en_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    value_d = in_value;
                    en_d    = digit_en;
                    idx_d   = 2'd0;
                    state_d = CONV;
                end
            end
            CONV: begin
                case (idx_q)
                    2'd0:    shadow_d[7:0]   = digit_code;
                    2'd1:    shadow_d[15:8]  = digit_code;
                    2'd2:    shadow_d[23:16] = digit_code;
                    default: shadow_d[31:24] = digit_code;
                endcase
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                out_d   = shadow_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered outputs follow the state being entered. in_ready comes
        // up in the cycle after a commit. update_done marks the commit edge.
        ready_d = (state_d == IDLE);
        done_d  = (state_q == COMMIT);
    end

    // State and datapath registers. Reset aborts any update in flight and
    // blanks the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            value_q  <= 16'h0000;
            en_q     <= 4'h0;
            shadow_q <= {4{BLANK_CODE}};
            out_q    <= {4{BLANK_CODE}};
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            en_q     <= en_d;
            shadow_q <= shadow_d;
            out_q    <= out_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign in_ready    = ready_q;
    assign out_7seg    = out_q;
    assign update_done = done_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_seg_display_sequencer.sv
module tb_seg_display_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_value = 16'h0;
  logic [3:0]  digit_en = 4'h0;
  logic [31:0] out_7seg;
  logic        busy;
  logic        update_done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] last_out = 32'hFFFF_FFFF;
  logic        prev_done = 1'b0;
  int          last_xfer = 0;

  // Active-high glyphs {g..a}, indexed by hex digit
  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  seg_display_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_value    (in_value),
    .digit_en    (digit_en),
    .out_7seg    (out_7seg),
    .busy        (busy),
    .update_done (update_done)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: frame the display shows after committing (v, e)
  function automatic logic [31:0] model(input logic [15:0] v, input logic [3:0] e);
    logic [31:0] f;
    int          upper;
    int          nib;
    f = 32'h0;
    for (int k = 0; k < 4; k++) begin
      upper = int'(v) >> (4 * k);
      nib   = upper % 16;
      if (!e[k])                   f[8*k +: 8] = 8'hFF;
      else if (k > 0 && upper == 0) f[8*k +: 8] = 8'hFF;
      else                          f[8*k +: 8] = ~seg_tab[nib];
    end
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: present a value, wait for in_ready, push the expected frame
  task automatic send(input logic [15:0] v, input logic [3:0] e, input bit hold);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    digit_en = e;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(v, e));
    cyc_q.push_back(cyc + 1);
    last_xfer = cyc + 1;
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    in_value = 16'($urandom);
    digit_en = 4'($urandom);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out  = 32'hFFFF_FFFF;
      prev_done = 1'b0;
    end else begin
      if (busy) check("ready_while_busy", 32'(in_ready), 32'd0);
      if (cyc_q.size() > 0 && cyc >= cyc_q[0] && cyc < cyc_q[0] + 5)
        check("busy_during_update", 32'(busy), 32'd1);
      if (update_done) begin
        check("done_one_cycle", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_update", 32'd1, 32'd0);
        end else begin
          check("frame", out_7seg, exp_q.pop_front());
          check("latency", 32'(cyc), 32'(cyc_q.pop_front() + 5));
        end
        last_out = out_7seg;
      end else begin
        check("out_hold", out_7seg, last_out);
      end
      prev_done = update_done;
    end
  end

  initial begin
    int t0;
    int wait_cnt;
    // clock/reset block; test 1
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", out_7seg, 32'hFFFF_FFFF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(update_done), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1 check("ready_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("ready_after_edge", 32'(in_ready), 32'd1);

    // directed patterns
    send(16'hF3A1, 4'hF, 1'b0);
    send(16'h0050, 4'hF, 1'b0);
    send(16'h0000, 4'hF, 1'b0);
    send(16'h1234, 4'b0101, 1'b0);
    send(16'h0007, 4'b1110, 1'b0);
    send(16'h8000, 4'hF, 1'b0);

    // back-to-back with in_valid held
    send(16'hABCD, 4'hF, 1'b1);
    t0 = last_xfer;
    send(16'h0102, 4'hF, 1'b1);
    check("b2b_spacing", 32'(last_xfer - t0), 32'd6);
    send(16'h9E6F, 4'b1011, 1'b0);

    // reset in the CONV cycle with idx = 2
    send(16'h4321, 4'hF, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out", out_7seg, 32'hFFFF_FFFF);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(update_done), 32'd0);
    exp_q.delete();
    cyc_q.delete();
    repeat (8) @(negedge clk);
    check("abort_hold", out_7seg, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    send(16'h4321, 4'hF, 1'b0);

    // random stimulus
    for (int i = 0; i < 40; i++) begin
      send(16'($urandom_range(0, 65535)) >> $urandom_range(0, 15),
           4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    in_valid = 1'b0;

    // drain the scoreboard
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
